// File: rtl/crossbar_multicast.sv
// Multicast crossbar: per-output select/enable with one output register stage.
// Route maps change only after all output registers have drained.
//
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   recv_*       : N_INPUTS val/rdy input channels (channel 0 in the top slice)
//   send_*       : N_OUTPUTS val/rdy output channels (channel 0 in the top slice)
//   control*     : val/rdy route-map port, one {en, sel} field per output
module crossbar_multicast #(
  parameter int BIT_WIDTH         = 32,
  parameter int N_INPUTS          = 4,
  parameter int N_OUTPUTS         = 4,
  parameter int SEL_W             = $clog2(N_INPUTS),
  parameter int CONTROL_BIT_WIDTH = N_OUTPUTS*(SEL_W+1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_INPUTS*BIT_WIDTH-1:0]  recv_msg,
  input  logic [0:N_INPUTS-1]            recv_val,
  output logic [0:N_INPUTS-1]            recv_rdy,
  output logic [N_OUTPUTS*BIT_WIDTH-1:0] send_msg,
  output logic [0:N_OUTPUTS-1]           send_val,
  input  logic [0:N_OUTPUTS-1]           send_rdy,
  input  logic [CONTROL_BIT_WIDTH-1:0]   control,
  input  logic                           control_val,
  output logic                           control_rdy
);

  localparam int FW = SEL_W + 1;

  logic [CONTROL_BIT_WIDTH-1:0] map_q;
  logic [0:N_OUTPUTS-1]         full_q;
  logic [BIT_WIDTH-1:0]         data_q   [N_OUTPUTS];

  logic [SEL_W-1:0]             sel      [N_OUTPUTS];
  logic [0:N_OUTPUTS-1]         live;
  logic [0:N_OUTPUTS-1]         can_acc;
  logic [0:N_OUTPUTS-1]         load;
  logic [BIT_WIDTH-1:0]         load_msg [N_OUTPUTS];
  logic [BIT_WIDTH-1:0]         in_msg   [N_INPUTS];
  logic [0:N_INPUTS-1]          used;
  logic [0:N_INPUTS-1]          blocked;
  logic [0:N_INPUTS-1]          fire;

  always_comb begin
    for (int j = 0; j < N_OUTPUTS; j++) begin
      sel[j]     = map_q[CONTROL_BIT_WIDTH-2-j*FW -: SEL_W];
      // out-of-range selects behave as a disabled output
      live[j]    = map_q[CONTROL_BIT_WIDTH-1-j*FW] &&
                   (32'(sel[j]) < 32'(N_INPUTS));
      can_acc[j] = !full_q[j] || send_rdy[j];
    end
  end

  always_comb begin
    for (int i = 0; i < N_INPUTS; i++)
      in_msg[i] = recv_msg[(N_INPUTS-1-i)*BIT_WIDTH +: BIT_WIDTH];
  end

  // An input is ready only if every branch of its fork can accept,
  // so a multicast either lands everywhere or nowhere.
  always_comb begin
    used    = '0;
    blocked = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      for (int j = 0; j < N_OUTPUTS; j++) begin
        if (live[j] && sel[j] == SEL_W'(i)) begin
          used[i] = 1'b1;
          if (!can_acc[j]) blocked[i] = 1'b1;
        end
      end
    end
    recv_rdy = used & ~blocked & {N_INPUTS{!control_val}};
    fire     = recv_val & recv_rdy;
  end

  always_comb begin
    for (int j = 0; j < N_OUTPUTS; j++) begin
      load[j]     = 1'b0;
      load_msg[j] = '0;
      for (int i = 0; i < N_INPUTS; i++) begin
        if (live[j] && sel[j] == SEL_W'(i) && fire[i]) begin
          load[j]     = 1'b1;
          load_msg[j] = in_msg[i];
        end
      end
    end
  end

  always_comb begin
    send_msg = '0;
    for (int j = 0; j < N_OUTPUTS; j++)
      send_msg[(N_OUTPUTS-1-j)*BIT_WIDTH +: BIT_WIDTH] =
        full_q[j] ? data_q[j] : '0;
  end

  assign send_val    = full_q;
  assign control_rdy = ~|full_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      map_q  <= '0;
      full_q <= '0;
      for (int j = 0; j < N_OUTPUTS; j++) data_q[j] <= '0;
    end else begin
      if (control_val && control_rdy) map_q <= control;
      for (int j = 0; j < N_OUTPUTS; j++) begin
        if (load[j]) begin
          full_q[j] <= 1'b1;
          data_q[j] <= load_msg[j];
        end else if (full_q[j] && send_rdy[j]) begin
          full_q[j] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/crossbar_multicast.md
Name: crossbar_multicast

Overview:
- Parametrised successor to the single-route crossbar. Each output has its own input select and enable, so several routes are live at once.
- Fan-out (multicast) is allowed: one input may drive several outputs.
- One registered pipeline stage sits on every output.
- Reconfiguration is handshaked. The block drains its in-flight data before a new route map takes effect.
- Sits between processing blocks as the programmable routing fabric, with route maps written over the control port.

Parameters:
- BIT_WIDTH, 32, message width per channel.
- N_INPUTS, 4, number of input channels (≥2).
- N_OUTPUTS, 4, number of output channels (≥1).
- SEL_W, $clog2(N_INPUTS), select field width (derived; do not override).
- CONTROL_BIT_WIDTH, N_OUTPUTS*(SEL_W+1), route-map width (derived).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- recv_msg  in  N_INPUTS*BIT_WIDTH  input messages; channel i at bits [((N_INPUTS-1)-i)*BIT_WIDTH +: BIT_WIDTH].
- recv_val  in  [0:N_INPUTS-1]  input valid, index i = channel i.
- recv_rdy  out  [0:N_INPUTS-1]  input ready.
- send_msg  out  N_OUTPUTS*BIT_WIDTH  output messages; channel j at bits [((N_OUTPUTS-1)-j)*BIT_WIDTH +: BIT_WIDTH].
- send_val  out  [0:N_OUTPUTS-1]  output valid.
- send_rdy  in  [0:N_OUTPUTS-1]  output ready.
- control  in  CONTROL_BIT_WIDTH  new route map.
- control_val  in  1  route map valid.
- control_rdy  out  1  route map accepted when high with control_val.

Behaviour:
- Clocking and reset: single clock domain. All state updates on posedge clk. Reset is synchronous and active-high.
- Route map layout: field j occupies bits [CONTROL_BIT_WIDTH-1-j*(SEL_W+1) -: SEL_W+1]. The field MSB is en[j]; the low SEL_W bits are sel[j].
- An output with sel[j] ≥ N_INPUTS is treated as disabled.
- Stored map: the map register holds the active route map.
  - Reset value is 0: all outputs disabled.
  - Loads `control` on the cycle where control_val && control_rdy.
  - The new map governs routing from the next cycle.
- Output stage: one register per output, holding a message plus a full bit.
  - send_val[j] = full[j].
  - send_msg[j] = reg[j] while full; 0 when empty.
  - can_acc[j] = !full[j] || send_rdy[j] (bypass-ready, full throughput).
- Input ready: recv_rdy[i] = !freeze && (some enabled j has sel[j]==i) && AND of can_acc[j] over all enabled j with sel[j]==i.
  - This is combinational from send_rdy and state.
  - recv_rdy must not depend on recv_val.
  - An input that no enabled output selects has recv_rdy=0.
- Fire: input i fires when recv_val[i] && recv_rdy[i]. On fire, every enabled output selecting i loads recv_msg[i] and sets full. All fork branches load in the same cycle (all-or-nothing).
- Drain: output j clears full when send_rdy[j] && full[j] and it is not being reloaded in the same cycle. Simultaneous drain and load keeps full=1 with the new data.
- Latency: one cycle from input fire to send_val.
- freeze = control_val. While a reconfiguration request is pending, no new inputs are accepted, so the buffers drain.
- control_rdy = control_val-independent AND of !full[j] over all j.
  - A map is therefore accepted only when every output register is empty.
  - No message is ever routed under a stale map or dropped.
- Control handshake rules:
  - control may be held with control_val high for any number of cycles.
  - Deasserting control_val before acceptance cancels the request and unfreezes inputs the next combinational evaluation.
- Reset mid-operation: all full bits clear, the map returns to 0, and all outputs go idle next cycle. In-flight data is discarded.
- Reset values: send_val=0, send_msg=0, recv_rdy=0, control_rdy=1.
- Size: a competent implementation is 150–300 lines of RTL.

Test Plan:
- Unicast: map out0←in2, out1←in0, out2/out3 disabled. Drive in2=0xAAAA0002 and in0=0x00000BB0 with all send_rdy=1. Required: the next cycle shows send_val=1100 with the matching messages. recv_rdy[1] and recv_rdy[3] stay 0.
- Multicast backpressure: map out0,out1,out3←in1. Hold send_rdy[1]=0 after the first message. Required: the second message stalls (recv_rdy[1]=0) until send_rdy[1] rises. Then all three outputs receive 0x12345678 on the same cycle, with no duplicate on out0.
- Throughput: stream 16 messages in3→out2 with send_rdy held high. Required: one message per cycle, each in order, with 1-cycle latency.
- Reconfig drain: out0 full with send_rdy[0]=0, and control_val asserted with a new map. Required:
  - control_rdy=0 and all recv_rdy=0.
  - After send_rdy[0]=1 for one cycle, control_rdy=1 and the map loads.
  - The next message follows the new route.
- Disabled and out-of-range select: with N_INPUTS=3, SEL_W=2, set a field to en=1, sel=3. Required: that output never asserts send_val, and no input is ready because of it.
- Reset mid-stream: assert reset with all outputs full. Required: next cycle send_val=0, send_msg=0, recv_rdy=0, control_rdy=1, and a post-reset map of 0 leaves all outputs disabled.
